lock_session_ctrl: RTL
======================

// Module: lock_session_ctrl
// PURPOSE
//  Session controller for the UART-fed keypad lock. Consumes received bytes (rx_data/rx_done),
//  sequences PIN entry, unlock window, PIN reprogramming and brute-force lockout.
//  Sits between the UART receiver and the door actuator / status LEDs.
//  Owns the stored code register, which reset loads from a parameter.
// PARAMETERS
//  PIN_LEN        4            digits per PIN (ASCII '0'..'9'), 1..8
//  DEFAULT_CODE   "1416"       reset value of stored code, PIN_LEN*8 bits, ASCII
//  TIMEOUT_CYC    50_000_000   max idle cycles between digits before partial entry is discarded
//  UNLOCK_CYC     250_000_000  cycles auth stays high after a correct PIN
//  LOCKOUT_CYC    500_000_000  cycles all input is ignored after MAX_FAIL misses
//  MAX_FAIL       3            consecutive wrong PINs that trigger lockout, >=1
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high
//  rx_data       in   8        received byte, valid only when rx_done=1
//  rx_done       in   1        1-cycle strobe, one byte per strobe
//  auth          out  1        1 = unlocked (UNLOCKED or PROG)
//  lockout       out  1        1 = in LOCKOUT
//  code_updated  out  1        1-cycle pulse when a new code is committed
//  fail_cnt      out  FW       consecutive wrong PINs, FW=$clog2(MAX_FAIL+1)
// BEHAVIOUR
//  Reset (sync, overrides everything incl. rx_done): state=ENTRY, auth=0, lockout=0,
//   code_updated=0, fail_cnt=0, digit count=0, entry shift reg=0, code=DEFAULT_CODE, timer idle.
//  Digit = rx_data in 8'h30..8'h39. Bytes are acted on only in the cycle rx_done=1.
//  Outputs are registered: every effect is visible the cycle after the rx_done cycle.
//  ENTRY: digit -> shift into entry reg, count++, reload idle timer (TIMEOUT_CYC).
//   '*' -> clear count/entry. Other bytes ignored.
//   PIN_LEN-th digit: compare {entry[(PIN_LEN-1)*8-1:0], rx_data} to code in the same cycle;
//   clear count/entry regardless of result.
//   match -> UNLOCKED, auth=1, fail_cnt=0, load timer UNLOCK_CYC.
//   miss  -> fail_cnt++; if new fail_cnt==MAX_FAIL -> LOCKOUT, lockout=1, load LOCKOUT_CYC.
//   Idle timer expiry with count!=0 -> clear count/entry; fail_cnt unchanged.
//   No timeout while count==0.
//  UNLOCKED: on timer expiry -> ENTRY, auth=0. 'L' -> ENTRY, auth=0 immediately.
//   'P' -> PROG, count cleared, load TIMEOUT_CYC. Other bytes ignored.
//  PROG (auth=1): digit -> shift/count, reload TIMEOUT_CYC.
//   PIN_LEN-th digit -> code <= new value, code_updated=1 for one cycle,
//   -> UNLOCKED, reload UNLOCK_CYC.
//   Any non-digit byte or timer expiry -> abort: code unchanged, -> UNLOCKED, reload UNLOCK_CYC.
//  LOCKOUT: all bytes ignored. On timer expiry -> ENTRY, lockout=0, fail_cnt=0.
//  Timer: down-counter, width $clog2(max(TIMEOUT_CYC,UNLOCK_CYC,LOCKOUT_CYC)+1).
//   A load of N cycles expires on exactly the Nth cycle after the load, counting the load
//   cycle as cycle 0. An event expiring in the same cycle as rx_done: the byte wins, and the
//   expiry is discarded (e.g. UNLOCKED expiry + 'P' -> PROG).
//  fail_cnt saturates at MAX_FAIL. No wrap. Counters never wrap.
//  Back-to-back rx_done on consecutive cycles must be handled without loss.
// STRUCTURE
//  Package lock_pkg: state enum {ENTRY, UNLOCKED, PROG, LOCKOUT}; ASCII constants
//   DIG_0/DIG_9, KEY_CLEAR='*', KEY_LOCK='L', KEY_PROG='P'.
//  Sub-module lock_timer: loadable down-counter with load value/load strobe/1-cycle expire
//   output, shared by all timeouts. FSM, shift register, code register and fail counter
//   live in this module.
// TESTING  (bench params: TIMEOUT_CYC=20, UNLOCK_CYC=50, LOCKOUT_CYC=30, MAX_FAIL=3)
//  "1416" -> auth=1 the cycle after the 4th strobe; auth=0 exactly 50 cycles later;
//   fail_cnt=0 throughout.
//  "1111" x3 -> fail_cnt 1,2,3, then lockout=1. During lockout "1416" gives auth=0.
//   After 30 cycles lockout=0 and fail_cnt=0, and "1416" gives auth=1.
//  "14", 25 idle cycles, then "16" -> no unlock (partial entry discarded).
//   "14*1416" -> auth=1.
//  Unlock, "P9876" -> code_updated pulse; "L" -> auth=0. "1416" now fails; "9876" unlocks.
//  Unlock, "P98x" -> abort, code stays "1416", auth stays 1 for 50 more cycles.
//  Reset asserted mid-entry and while UNLOCKED after reprogram -> all outputs 0, and
//   "1416" unlocks again (DEFAULT_CODE restored).

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock session controller.
//   state_e      : session FSM states
//   DIG_0/DIG_9  : ASCII range accepted as PIN digits
//   KEY_*        : command bytes recognised by the session controller
//   max3         : helper used to size the shared timer
package lock_pkg;

  typedef enum logic [1:0] {ENTRY, UNLOCKED, PROG, LOCKOUT} state_e;

  localparam logic [7:0] DIG_0     = 8'h30;  // '0'
  localparam logic [7:0] DIG_9     = 8'h39;  // '9'
  localparam logic [7:0] KEY_CLEAR = 8'h2A;  // '*'
  localparam logic [7:0] KEY_LOCK  = 8'h4C;  // 'L'
  localparam logic [7:0] KEY_PROG  = 8'h50;  // 'P'

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timeout of the session controller.
//   clk      : system clock
//   reset    : synchronous, active-high; leaves the timer idle
//   load     : load strobe, takes priority over counting
//   load_val : cycles until expiry (load cycle counts as cycle 0)
//   expire   : 1-cycle pulse in the load_val-th cycle after the load
module lock_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expire
);

  logic [Width-1:0] cnt_q;

  // Zero means idle; a load of N holds N in the cycle after the load and
  // reaches 1 in the Nth cycle, which is where the pulse is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == Width'(1));

endmodule

// File: rtl/lock_session_ctrl.sv
// Session controller for the UART-fed keypad lock: PIN entry, unlock window,
// PIN reprogramming and brute-force lockout. Owns the stored code register.
//   clk          : system clock
//   reset        : synchronous, active-high
//   rx_data      : received byte, valid while rx_done=1
//   rx_done      : 1-cycle strobe per received byte
//   auth         : 1 while UNLOCKED or PROG
//   lockout      : 1 while in LOCKOUT
//   code_updated : 1-cycle pulse when a new code is committed
//   fail_cnt     : consecutive wrong PINs, saturating at MAX_FAIL
module lock_session_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned           PIN_LEN      = 4,
  parameter logic [PIN_LEN*8-1:0]  DEFAULT_CODE = "1416",
  parameter int unsigned           TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned           UNLOCK_CYC   = 250_000_000,
  parameter int unsigned           LOCKOUT_CYC  = 500_000_000,
  parameter int unsigned           MAX_FAIL     = 3,
  localparam int unsigned          FW           = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          auth,
  output logic          lockout,
  output logic          code_updated,
  output logic [FW-1:0] fail_cnt
);

  localparam int unsigned W  = PIN_LEN * 8;
  localparam int unsigned CW = $clog2(PIN_LEN + 1);
  localparam int unsigned TW = $clog2(max3(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC) + 1);

  state_e          state_q;
  logic [W-1:0]    entry_q;
  logic [W-1:0]    code_q;
  logic [CW-1:0]   digit_cnt_q;

  logic            is_digit;
  logic            last_digit;
  logic            pin_match;
  logic            fail_hit;
  logic [W-1:0]    next_entry;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expire;

  assign is_digit   = (rx_data >= DIG_0) && (rx_data <= DIG_9);
  assign last_digit = (digit_cnt_q == CW'(PIN_LEN - 1));
  // Shift the new byte in; the oldest digit falls off the top.
  assign next_entry = W'({entry_q, rx_data});
  assign pin_match  = (next_entry == code_q);
  // This miss would bring the count up to MAX_FAIL.
  assign fail_hit   = (({1'b0, fail_cnt} + (FW + 1)'(1)) == (FW + 1)'(MAX_FAIL));

  lock_timer #(
    .Width (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Timer loads must land in the same cycle as the byte that causes them.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(TIMEOUT_CYC);
    case (state_q)
      ENTRY: begin
        if (rx_done && is_digit) begin
          tmr_load = 1'b1;
          if (last_digit && pin_match) begin
            tmr_val = TW'(UNLOCK_CYC);
          end else if (last_digit && fail_hit) begin
            tmr_val = TW'(LOCKOUT_CYC);
          end
        end
      end
      UNLOCKED: begin
        if (rx_done && (rx_data == KEY_PROG)) begin
          tmr_load = 1'b1;
        end
      end
      PROG: begin
        // Every byte and every expiry in PROG ends in a reload; only a
        // non-final digit keeps the short entry timeout.
        if (rx_done || tmr_expire) begin
          tmr_load = 1'b1;
          if (!(rx_done && is_digit && !last_digit)) begin
            tmr_val = TW'(UNLOCK_CYC);
          end
        end
      end
      default: ;
    endcase
  end

  // A byte that is acted on wins over a coincident expiry; bytes the current
  // state ignores let the expiry through, so LOCKOUT can always end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ENTRY;
      entry_q      <= '0;
      code_q       <= DEFAULT_CODE;
      digit_cnt_q  <= '0;
      auth         <= 1'b0;
      lockout      <= 1'b0;
      code_updated <= 1'b0;
      fail_cnt     <= '0;
    end else begin
      code_updated <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (rx_done && is_digit) begin
            if (last_digit) begin
              entry_q     <= '0;
              digit_cnt_q <= '0;
              if (pin_match) begin
                state_q  <= UNLOCKED;
                auth     <= 1'b1;
                fail_cnt <= '0;
              end else if (fail_hit) begin
                state_q  <= LOCKOUT;
                lockout  <= 1'b1;
                fail_cnt <= FW'(MAX_FAIL);
              end else begin
                fail_cnt <= fail_cnt + 1'b1;
              end
            end else begin
              entry_q     <= next_entry;
              digit_cnt_q <= digit_cnt_q + 1'b1;
            end
          end else if (rx_done && (rx_data == KEY_CLEAR)) begin
            entry_q     <= '0;
            digit_cnt_q <= '0;
          end else if (tmr_expire && (digit_cnt_q != '0)) begin
            entry_q     <= '0;
            digit_cnt_q <= '0;
          end
        end
        UNLOCKED: begin
          if (rx_done && (rx_data == KEY_LOCK)) begin
            state_q <= ENTRY;
            auth    <= 1'b0;
          end else if (rx_done && (rx_data == KEY_PROG)) begin
            state_q     <= PROG;
            entry_q     <= '0;
            digit_cnt_q <= '0;
          end else if (tmr_expire) begin
            state_q <= ENTRY;
            auth    <= 1'b0;
          end
        end
        PROG: begin
          if (rx_done && is_digit) begin
            if (last_digit) begin
              code_q       <= next_entry;
              code_updated <= 1'b1;
              state_q      <= UNLOCKED;
              entry_q      <= '0;
              digit_cnt_q  <= '0;
            end else begin
              entry_q     <= next_entry;
              digit_cnt_q <= digit_cnt_q + 1'b1;
            end
          end else if (rx_done || tmr_expire) begin
            // Abort: the stored code is left untouched.
            state_q     <= UNLOCKED;
            entry_q     <= '0;
            digit_cnt_q <= '0;
          end
        end
        LOCKOUT: begin
          if (tmr_expire) begin
            state_q  <= ENTRY;
            lockout  <= 1'b0;
            fail_cnt <= '0;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

endmodule
